// File: rtl/arbitro_tx_serial_pkg.sv
// Shared definitions for the serial TX arbiter: FSM states, grant encodings
// and the default byte width.
package arbitro_tx_serial_pkg;

  localparam int DATA_W_PADRAO = 8;

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    ENVIA       = 2'd1,
    AGUARDA_FIM = 2'd2
  } estado_t;

  localparam logic [1:0] CONC_NENHUM = 2'b00;
  localparam logic [1:0] CONC_SRC0   = 2'b01;
  localparam logic [1:0] CONC_SRC1   = 2'b10;

  function automatic logic [1:0] concedido_de(input logic idx);
    return idx ? CONC_SRC1 : CONC_SRC0;
  endfunction

endpackage

// File: rtl/arbitro_tx_serial_contador_timeout.sv
// Stall counter for the arbiter: pulses fim after LIMITE consecutive enabled
// cycles. Only compiled with ARBITRO_TIMEOUT_EN defined.
`ifdef ARBITRO_TIMEOUT_EN
module contador_timeout #(
  parameter int LIMITE = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic fim
);

  localparam int CNT_W = $clog2(LIMITE + 1);

  logic [CNT_W-1:0] cnt_reg;

  assign fim = enable && (cnt_reg == CNT_W'(LIMITE - 1));

  always_ff @(posedge clock) begin
    if (reset || clear || fim) begin
      cnt_reg <= '0;
    end else if (enable) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/arbitro_tx_serial.sv
// Packet-level round-robin arbiter sharing one serial TX between two byte
// sources. Optional stall timeout enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_tx_serial
  import arbitro_tx_serial_pkg::*;
#(
  parameter int DATA_W         = DATA_W_PADRAO,
  parameter int TIMEOUT_CICLOS = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_dado,
  input  logic              req0_ultimo,
  output logic              req0_pronto,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_dado,
  input  logic              req1_ultimo,
  output logic              req1_pronto,
  output logic              tx_partida,
  output logic [DATA_W-1:0] tx_dado,
  input  logic              tx_fim,
  output logic [1:0]        concedido,
  output logic              erro_timeout
);

  estado_t           estado_reg;
  logic              idx_reg;
  logic              prio_reg;
  logic              ultimo_reg;
  logic [1:0]        concedido_reg;
  logic              tx_partida_reg;
  logic [DATA_W-1:0] tx_dado_reg;
  logic              pronto0_reg;
  logic              pronto1_reg;

  logic              idx_next;
  logic              sel_valid;
  logic              sel_ultimo;
  logic [DATA_W-1:0] sel_dado;

  // A lone requester always wins; prio only breaks ties.
  always_comb begin
    idx_next = req1_valid;
    if (req0_valid && req1_valid) begin
      idx_next = prio_reg;
    end
  end

  assign sel_valid  = idx_reg ? req1_valid  : req0_valid;
  assign sel_ultimo = idx_reg ? req1_ultimo : req0_ultimo;
  assign sel_dado   = idx_reg ? req1_dado   : req0_dado;

`ifdef ARBITRO_TIMEOUT_EN
  logic timeout_fim;
  logic erro_reg;

  contador_timeout #(
    .LIMITE (TIMEOUT_CICLOS)
  ) u_contador (
    .clock  (clock),
    .reset  (reset),
    .clear  ((estado_reg != ENVIA) || sel_valid),
    .enable ((estado_reg == ENVIA) && !sel_valid),
    .fim    (timeout_fim)
  );

  assign erro_timeout = erro_reg;
`else
  assign erro_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_reg     <= OCIOSO;
      idx_reg        <= 1'b0;
      prio_reg       <= 1'b0;
      ultimo_reg     <= 1'b0;
      concedido_reg  <= CONC_NENHUM;
      tx_partida_reg <= 1'b0;
      tx_dado_reg    <= '0;
      pronto0_reg    <= 1'b0;
      pronto1_reg    <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      erro_reg       <= 1'b0;
`endif
    end else begin
      tx_partida_reg <= 1'b0;
      pronto0_reg    <= 1'b0;
      pronto1_reg    <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      erro_reg       <= 1'b0;
`endif
      case (estado_reg)
        OCIOSO: begin
          if (req0_valid || req1_valid) begin
            idx_reg       <= idx_next;
            concedido_reg <= concedido_de(idx_next);
            estado_reg    <= ENVIA;
          end
        end
        ENVIA: begin
          if (sel_valid) begin
            tx_partida_reg <= 1'b1;
            tx_dado_reg    <= sel_dado;
            pronto0_reg    <= !idx_reg;
            pronto1_reg    <= idx_reg;
            ultimo_reg     <= sel_ultimo;
            estado_reg     <= AGUARDA_FIM;
          end
`ifdef ARBITRO_TIMEOUT_EN
          else if (timeout_fim) begin
            erro_reg      <= 1'b1;
            concedido_reg <= CONC_NENHUM;
            prio_reg      <= ~idx_reg;
            estado_reg    <= OCIOSO;
          end
`endif
        end
        AGUARDA_FIM: begin
          // Next byte is only requested once the TX reports the stop bit done.
          if (tx_fim) begin
            if (ultimo_reg) begin
              concedido_reg <= CONC_NENHUM;
              prio_reg      <= ~idx_reg;
              estado_reg    <= OCIOSO;
            end else begin
              estado_reg    <= ENVIA;
            end
          end
        end
        default: begin
          concedido_reg <= CONC_NENHUM;
          estado_reg    <= OCIOSO;
        end
      endcase
    end
  end

  assign req0_pronto = pronto0_reg;
  assign req1_pronto = pronto1_reg;
  assign tx_partida  = tx_partida_reg;
  assign tx_dado     = tx_dado_reg;
  assign concedido   = concedido_reg;

endmodule

// File: tb/tb_arbitro_tx_serial.sv
// Scoreboard bench for arbitro_tx_serial: packet-level round-robin model,
// source/TX behavioural models and an independent output monitor.
module tb_arbitro_tx_serial;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid, req0_ultimo, req1_valid, req1_ultimo;
  logic [7:0] req0_dado, req1_dado;
  logic       req0_pronto, req1_pronto;
  logic       tx_partida, tx_fim, erro_timeout;
  logic [7:0] tx_dado;
  logic [1:0] concedido;

  always #5 clock = ~clock;

  arbitro_tx_serial #(
    .DATA_W         (8),
    .TIMEOUT_CICLOS (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_dado    (req0_dado),
    .req0_ultimo  (req0_ultimo),
    .req0_pronto  (req0_pronto),
    .req1_valid   (req1_valid),
    .req1_dado    (req1_dado),
    .req1_ultimo  (req1_ultimo),
    .req1_pronto  (req1_pronto),
    .tx_partida   (tx_partida),
    .tx_dado      (tx_dado),
    .tx_fim       (tx_fim),
    .concedido    (concedido),
    .erro_timeout (erro_timeout)
  );

  int checks = 0;
  int failures = 0;

  logic [8:0] q0[$];     // {ultimo, byte} queued in each source
  logic [8:0] q1[$];
  logic [8:0] exp_q[$];  // {source, byte} expected on the TX
  int         allow0 = 1 << 30;
  int         tx_fixo = 0;
  logic       tx_busy = 1'b0;
  int         tx_cnt = 0;
  int         n_partidas = 0;
  logic       m_prio = 1'b0;

  logic [7:0] vb0[$], vb1[$];
  int         vl0[$], vl1[$];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nome, got, want, $time);
    end
  endtask

  // Sources and TX model: react just after each rising edge.
  initial begin
    req0_valid = 0; req0_dado = 0; req0_ultimo = 0;
    req1_valid = 0; req1_dado = 0; req1_ultimo = 0;
    tx_fim = 0;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        if (req0_pronto && q0.size() > 0) begin void'(q0.pop_front()); allow0--; end
        if (req1_pronto && q1.size() > 0) void'(q1.pop_front());
      end
      req0_valid  = (q0.size() > 0) && (allow0 > 0);
      req0_dado   = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      req0_ultimo = (q0.size() > 0) ? q0[0][8] : 1'b0;
      req1_valid  = (q1.size() > 0);
      req1_dado   = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      req1_ultimo = (q1.size() > 0) ? q1[0][8] : 1'b0;
      tx_fim = 1'b0;
      if (tx_partida && !reset) begin
        check("partida_sem_fim", {31'd0, tx_busy}, 0);
        tx_busy = 1'b1;
        tx_cnt  = (tx_fixo > 0) ? tx_fixo : int'($urandom_range(2, 12));
      end else if (tx_busy) begin
        tx_cnt--;
        if (tx_cnt == 0) begin tx_fim = 1'b1; tx_busy = 1'b0; end
      end
    end
  end

  // Monitor: pops the scoreboard on every TX start.
  initial begin : monitor
    logic [8:0] e;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        if (tx_partida) begin
          n_partidas++;
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL partida_inesperada: got dado=%0h want no partida", tx_dado);
          end else begin
            e = exp_q.pop_front();
            $display("tx byte=%02h src=%0d concedido=%b", tx_dado, e[8], concedido);
            check("tx_dado", {24'd0, tx_dado}, {24'd0, e[7:0]});
            check("pronto", {30'd0, req1_pronto, req0_pronto}, e[8] ? 2 : 1);
            check("concedido", {30'd0, concedido}, e[8] ? 2 : 1);
          end
        end else if (req0_pronto || req1_pronto) begin
          checks++; failures++;
          $display("FAIL pronto_sem_partida: got %b%b want 00", req1_pronto, req0_pronto);
        end
`ifndef ARBITRO_TIMEOUT_EN
        if (erro_timeout) begin
          checks++; failures++;
          $display("FAIL erro_timeout: got 1 want 0");
        end
`endif
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Reference model: whole packets, alternating while both sources have one,
  // starting from the source holding priority.
  task automatic run_fase();
    int i0 = 0, i1 = 0, o0 = 0, o1 = 0;
    logic pick;
    while (i0 < vl0.size() || i1 < vl1.size()) begin
      if (i0 < vl0.size() && i1 < vl1.size()) pick = m_prio;
      else pick = (i1 < vl1.size());
      if (!pick) begin
        for (int k = 0; k < vl0[i0]; k++) exp_q.push_back({1'b0, vb0[o0 + k]});
        o0 += vl0[i0]; i0++;
      end else begin
        for (int k = 0; k < vl1[i1]; k++) exp_q.push_back({1'b1, vb1[o1 + k]});
        o1 += vl1[i1]; i1++;
      end
      m_prio = ~pick;
    end
    o0 = 0;
    for (int p = 0; p < vl0.size(); p++) begin
      for (int k = 0; k < vl0[p]; k++) q0.push_back({k == vl0[p] - 1, vb0[o0 + k]});
      o0 += vl0[p];
    end
    o1 = 0;
    for (int p = 0; p < vl1.size(); p++) begin
      for (int k = 0; k < vl1[p]; k++) q1.push_back({k == vl1[p] - 1, vb1[o1 + k]});
      o1 += vl1[p];
    end
  endtask

  task automatic wait_idle(input string nome);
    int n = 0;
    while (!(exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
             !tx_busy && concedido == 2'b00) && n < 3000) begin
      tick(1); n++;
    end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL idle_%s: got pending exp=%0d concedido=%b want drained", nome, exp_q.size(), concedido);
    end else begin
      check({"idle_", nome}, {30'd0, concedido}, 0);
    end
  endtask

  task automatic wait_exp_empty(input string nome);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin tick(1); n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL wait_%s: got exp=%0d want 0", nome, exp_q.size());
    end
  endtask

  initial begin
    int p;
    int k;
    // T1: reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_concedido", {30'd0, concedido}, 0);
    check("rst_partida", {31'd0, tx_partida}, 0);
    check("rst_dado", {24'd0, tx_dado}, 0);
    check("rst_pronto", {30'd0, req1_pronto, req0_pronto}, 0);
    check("rst_erro", {31'd0, erro_timeout}, 0);
    reset = 1'b0;
    tick(2);

    // T3: tie from reset, two 2-byte packets per source
    vb0 = '{8'h10, 8'h11, 8'h10, 8'h11}; vl0 = '{2, 2};
    vb1 = '{8'h20, 8'h21, 8'h20, 8'h21}; vl1 = '{2, 2};
    run_fase(); wait_idle("t3");

    // T2: single source, fixed TX latency
    tx_fixo = 10;
    vb0 = '{8'hA1, 8'hA2, 8'hA3}; vl0 = '{3};
    vb1.delete(); vl1.delete();
    run_fase(); wait_idle("t2");
    tx_fixo = 0;

    // T4: src1 arrives during a src0 packet
    vb0 = '{8'h40, 8'h41, 8'h42, 8'h43}; vl0 = '{4};
    run_fase();
    k = 0;
    while (concedido != 2'b01 && k < 50) begin tick(1); k++; end
    check("t4_grant0", {30'd0, concedido}, 1);
    vb0.delete(); vl0.delete();
    vb1 = '{8'h50, 8'h51}; vl1 = '{2};
    run_fase(); wait_idle("t4");

    // T5: src0 stalls after the first byte of three, src1 waits
    vb1.delete(); vl1.delete();
    allow0 = 1;
    q0.push_back({1'b0, 8'hB1}); q0.push_back({1'b0, 8'hB2}); q0.push_back({1'b1, 8'hB3});
    exp_q.push_back({1'b0, 8'hB1});
    wait_exp_empty("t5_b1");
    p = n_partidas;
    q1.push_back({1'b0, 8'hC5}); q1.push_back({1'b1, 8'hC6});
`ifdef ARBITRO_TIMEOUT_EN
    k = 0;
    while (!erro_timeout && k < 200) begin tick(1); k++; end
    check("t5_janela_timeout", {31'd0, (k >= 16 && k <= 40)}, 1);
    check("t5_concedido_timeout", {30'd0, concedido}, 0);
    q0.delete(); allow0 = 1 << 30;
    exp_q.push_back({1'b1, 8'hC5}); exp_q.push_back({1'b1, 8'hC6});
    m_prio = 1'b0;
`else
    tick(40);
    check("t5_stall_concedido", {30'd0, concedido}, 1);
    check("t5_stall_partidas", n_partidas, p);
    exp_q.push_back({1'b0, 8'hB2}); exp_q.push_back({1'b0, 8'hB3});
    exp_q.push_back({1'b1, 8'hC5}); exp_q.push_back({1'b1, 8'hC6});
    m_prio = 1'b0;
    allow0 = 1 << 30;
`endif
    wait_idle("t5");

    // T6: reset while waiting for tx_fim of byte 2; late tx_fim must be ignored
    tx_fixo = 6;
    q0.push_back({1'b0, 8'hD1}); q0.push_back({1'b0, 8'hD2}); q0.push_back({1'b1, 8'hD3});
    exp_q.push_back({1'b0, 8'hD1}); exp_q.push_back({1'b0, 8'hD2});
    wait_exp_empty("t6_d2");
    reset = 1'b1;
    q0.delete(); q1.delete(); exp_q.delete();
    tick(1);
    check("t6_concedido", {30'd0, concedido}, 0);
    check("t6_partida", {31'd0, tx_partida}, 0);
    check("t6_dado", {24'd0, tx_dado}, 0);
    check("t6_pronto", {30'd0, req1_pronto, req0_pronto}, 0);
    reset = 1'b0;
    m_prio = 1'b0;
    p = n_partidas;
    tick(15);
    check("t6_sem_partida", n_partidas, p);
    check("t6_ocioso", {30'd0, concedido}, 0);
    tx_fixo = 0;

    // Randomized rounds: both sources loaded together
    for (int r = 0; r < 8; r++) begin
      vb0.delete(); vl0.delete(); vb1.delete(); vl1.delete();
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        vl0.push_back(int'($urandom_range(1, 4)));
        for (int j = 0; j < vl0[i]; j++) vb0.push_back(8'($urandom));
      end
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        vl1.push_back(int'($urandom_range(1, 4)));
        for (int j = 0; j < vl1[i]; j++) vb1.push_back(8'($urandom));
      end
      run_fase();
      wait_idle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1, "watchdog");
  end

endmodule
